// File: rtl/btn_conditioner_if.sv
// Button front-end bundle: raw pins in, debounced level and event strobes out.
// The master side drives the pins; the conditioner sits on the slave side.
interface btn_conditioner_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0] btn_in;
   logic [N_CH-1:0] level;
   logic [N_CH-1:0] press_p;
   logic [N_CH-1:0] release_p;
   logic [N_CH-1:0] long_p;
   logic [N_CH-1:0] repeat_p;

   modport master (
      output btn_in,
      input  level, press_p, release_p, long_p, repeat_p
   );

   modport slave (
      input  btn_in,
      output level, press_p, release_p, long_p, repeat_p
   );
endinterface

// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner: 2-flop sync, debounce, press/release edges and
// long-press / auto-repeat classification, all outputs registered.
module btn_conditioner #(
   parameter int              N_CH        = 4,
   parameter int              DEB_CYCLES  = 1_000_000,
   parameter int              LONG_CYCLES = 100_000_000,
   parameter int              REP_CYCLES  = 20_000_000,
   parameter logic [N_CH-1:0] ACT_LOW     = '0,
   parameter logic [N_CH-1:0] REP_EN      = '0
) (
   input logic              clk,
   input logic              rst,
   btn_conditioner_if.slave bus
);
   localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
   localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
   localparam int RW = (REP_CYCLES  > 1) ? $clog2(REP_CYCLES)  : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HELD,
      ST_LONG
   } state_t;

   logic [N_CH-1:0] level_v;
   logic [N_CH-1:0] press_v;
   logic [N_CH-1:0] release_v;
   logic [N_CH-1:0] long_v;
   logic [N_CH-1:0] repeat_v;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic          x;
      logic [1:0]    sync_q, sync_d;
      logic          s;
      logic [DW-1:0] deb_cnt_q, deb_cnt_d;
      logic          level_q, level_d;
      logic          rise, fall;
      state_t        state_q, state_d;
      logic [HW-1:0] hold_cnt_q, hold_cnt_d;
      logic [RW-1:0] rep_cnt_q, rep_cnt_d;
      logic          press_q, press_d;
      logic          release_q, release_d;
      logic          long_q, long_d;
      logic          repeat_q, repeat_d;

      assign x      = bus.btn_in[g] ^ ACT_LOW[g];
      assign sync_d = {sync_q[0], x};
      assign s      = sync_q[1];

      always_comb begin
         level_d   = level_q;
         deb_cnt_d = '0;
         if (s != level_q) begin
            if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
               level_d = s;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
      end

      // Edges come from the debounced next-state so strobes align with the level flip.
      assign rise = ~level_q &  level_d;
      assign fall =  level_q & ~level_d;

      always_comb begin
         state_d    = state_q;
         hold_cnt_d = hold_cnt_q;
         rep_cnt_d  = rep_cnt_q;
         press_d    = 1'b0;
         release_d  = 1'b0;
         long_d     = 1'b0;
         repeat_d   = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  state_d    = ST_HELD;
                  press_d    = 1'b1;
                  hold_cnt_d = '0;
               end
            end
            ST_HELD: begin
               if (fall) begin
                  state_d   = ST_IDLE;
                  release_d = 1'b1;
               end else if (hold_cnt_q == HW'(LONG_CYCLES - 1)) begin
                  state_d   = ST_LONG;
                  long_d    = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            ST_LONG: begin
               if (fall) begin
                  state_d   = ST_IDLE;
                  release_d = 1'b1;
               end else if (REP_EN[g]) begin
                  if (rep_cnt_q == RW'(REP_CYCLES - 1)) begin
                     repeat_d  = 1'b1;
                     rep_cnt_d = '0;
                  end else begin
                     rep_cnt_d = rep_cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_q     <= '0;
            deb_cnt_q  <= '0;
            level_q    <= 1'b0;
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
         end else begin
            sync_q     <= sync_d;
            deb_cnt_q  <= deb_cnt_d;
            level_q    <= level_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
         end
      end

      assign level_v[g]   = level_q;
      assign press_v[g]   = press_q;
      assign release_v[g] = release_q;
      assign long_v[g]    = long_q;
      assign repeat_v[g]  = repeat_q;
   end

   assign bus.level     = level_v;
   assign bus.press_p   = press_v;
   assign bus.release_p = release_v;
   assign bus.long_p    = long_v;
   assign bus.repeat_p  = repeat_v;
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: every cycle of each scenario is compared against
// hand-derived expectations packed as {level, press_p, release_p, long_p, repeat_p}.
module tb_btn_conditioner;
   localparam int N_CH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   btn_conditioner_if #(.N_CH(N_CH)) bus ();

   btn_conditioner #(
      .N_CH(4),
      .DEB_CYCLES(4),
      .LONG_CYCLES(20),
      .REP_CYCLES(8),
      .ACT_LOW(4'b1000),
      .REP_EN(4'b0010)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [19:0] obs;
   assign obs = {bus.level, bus.press_p, bus.release_p, bus.long_p, bus.repeat_p};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      bus.btn_in = 4'b1000;
      #2;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (obs !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d: got %h expected %h", k, obs, 20'h0);
         end
      end
      rst = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         tick();
         n_checks++;
         if (obs !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_exit cycle %0d: got %h expected %h", k, obs, 20'h0);
         end
      end
   endtask

   task automatic test_glitch();
      bus.btn_in[0] = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         n_checks++;
         if (obs !== 20'h0) begin
            n_fail++;
            $display("FAIL glitch cycle %0d: got %h expected %h", k, obs, 20'h0);
         end
         if (k == 3) bus.btn_in[0] = 1'b0;
      end
   endtask

   task automatic test_short_press();
      logic [3:0] lv, pr, rl;
      logic [19:0] exp_v;
      bus.btn_in[0] = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         tick();
         lv = (k >= 6 && k < 16) ? 4'b0001 : 4'b0000;
         pr = (k == 6)  ? 4'b0001 : 4'b0000;
         rl = (k == 16) ? 4'b0001 : 4'b0000;
         exp_v = {lv, pr, rl, 4'b0000, 4'b0000};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL short_press cycle %0d: got %h expected %h", k, obs, exp_v);
         end
         if (k == 10) bus.btn_in[0] = 1'b0;
      end
   endtask

   task automatic test_long_repeat();
      logic [3:0] lv, pr, rl, lg, rp;
      logic [19:0] exp_v;
      bus.btn_in[1:0] = 2'b11;
      for (int k = 1; k <= 72; k++) begin
         tick();
         lv = (k >= 6 && k < 66) ? 4'b0011 : 4'b0000;
         pr = (k == 6)  ? 4'b0011 : 4'b0000;
         lg = (k == 26) ? 4'b0011 : 4'b0000;
         rp = (k > 26 && k < 66 && (k - 26) % 8 == 0) ? 4'b0010 : 4'b0000;
         rl = (k == 66) ? 4'b0011 : 4'b0000;
         exp_v = {lv, pr, rl, lg, rp};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL long_repeat cycle %0d: got %h expected %h", k, obs, exp_v);
         end
         if (k == 60) bus.btn_in[1:0] = 2'b00;
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] lv, pr, rl;
      logic [19:0] exp_v;
      bus.btn_in = 4'b0101;
      for (int k = 1; k <= 22; k++) begin
         tick();
         lv = (k >= 6 && k < 16) ? 4'b1101 : 4'b0000;
         pr = (k == 6)  ? 4'b1101 : 4'b0000;
         rl = (k == 16) ? 4'b1101 : 4'b0000;
         exp_v = {lv, pr, rl, 4'b0000, 4'b0000};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL simultaneous cycle %0d: got %h expected %h", k, obs, exp_v);
         end
         if (k == 10) bus.btn_in = 4'b1000;
      end
   endtask

   task automatic test_reset_mid_press();
      logic [3:0] lv, pr, rl, lg;
      logic [19:0] exp_v;
      bus.btn_in[1] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         lv = (k >= 6) ? 4'b0010 : 4'b0000;
         pr = (k == 6)  ? 4'b0010 : 4'b0000;
         lg = (k == 26) ? 4'b0010 : 4'b0000;
         exp_v = {lv, pr, 4'b0000, lg, 4'b0000};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL pre_reset cycle %0d: got %h expected %h", k, obs, exp_v);
         end
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (obs !== 20'h0) begin
         n_fail++;
         $display("FAIL async_clear: got %h expected %h", obs, 20'h0);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_checks++;
         if (obs !== 20'h0) begin
            n_fail++;
            $display("FAIL mid_reset cycle %0d: got %h expected %h", k, obs, 20'h0);
         end
      end
      rst = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         lv = (k >= 6 && k < 40) ? 4'b0010 : 4'b0000;
         pr = (k == 6)  ? 4'b0010 : 4'b0000;
         lg = (k == 26) ? 4'b0010 : 4'b0000;
         rl = (k == 40) ? 4'b0010 : 4'b0000;
         exp_v = {lv, pr, rl, lg, (k == 34) ? 4'b0010 : 4'b0000};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL post_reset cycle %0d: got %h expected %h", k, obs, exp_v);
         end
         if (k == 34) bus.btn_in[1] = 1'b0;
      end
   endtask

   initial begin
      bus.btn_in = 4'b1000;
      test_reset();
      test_glitch();
      test_short_press();
      test_long_repeat();
      test_simultaneous();
      test_reset_mid_press();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end
endmodule
